// File: rtl/ram_load_arbiter.sv
// RAM port owner for the 8-bit core: muxes the CPU control path with a byte-stream
// program loader that freezes the sequencer, holds the CPU in reset and fills RAM from 0.
module ram_load_arbiter #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int LOAD_LEN  = 16,
    parameter int WR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_ri,
    input  logic              cpu_ro,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_oe,
    output logic              prog_mode,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] checksum,
    output logic              conflict
);

    localparam int                CNT_W     = $clog2(WR_CYCLES + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_LEN - 1);
    localparam logic [CNT_W-1:0]  WR_LAST   = CNT_W'(WR_CYCLES);

    typedef enum logic [2:0] {IDLE, ARM, RECV, WRITE, FINISH} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  load_addr;
    logic [DATA_W-1:0]  data_q;
    logic [CNT_W-1:0]   wr_cnt;
    logic               ld_we;
    logic               abort_hit, accept, wr_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        abort_hit = 1'b0;
        accept    = 1'b0;
        wr_end    = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = ARM;
            ARM: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = RECV;
                end
            end
            RECV: begin
                // abort outranks a same-cycle handshake: the byte is dropped
                if (abort) begin
                    abort_hit = 1'b1;
                    state_d   = IDLE;
                end else if (in_valid) begin
                    accept  = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    abort_hit = 1'b1;
                    state_d   = IDLE;
                end else if (wr_cnt == WR_LAST) begin
                    wr_end  = 1'b1;
                    state_d = (load_addr == LAST_ADDR) ? FINISH : RECV;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_addr <= '0;
            data_q    <= '0;
            wr_cnt    <= '0;
            ld_we     <= 1'b0;
            checksum  <= '0;
            prog_mode <= 1'b0;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_hit) begin
                err       <= 1'b1;
                busy      <= 1'b0;
                prog_mode <= 1'b0;
                cpu_rst_n <= 1'b0;
                ld_we     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        // a failed load keeps the CPU parked until a clean load or rst
                        cpu_rst_n <= ~err;
                        if (start) begin
                            err       <= 1'b0;
                            checksum  <= '0;
                            load_addr <= '0;
                        end
                    end
                    ARM: begin
                        prog_mode <= 1'b1;
                        cpu_rst_n <= 1'b0;
                        busy      <= 1'b1;
                    end
                    RECV: begin
                        if (accept) begin
                            data_q   <= in_data;
                            checksum <= checksum + in_data;
                            wr_cnt   <= '0;
                            ld_we    <= 1'b1;
                        end
                    end
                    WRITE: begin
                        // strobe spans WR_CYCLES; the extra trailing cycle holds addr/data
                        wr_cnt <= wr_cnt + 1'b1;
                        ld_we  <= (int'(wr_cnt) + 1 < WR_CYCLES);
                        if (wr_end && load_addr != LAST_ADDR)
                            load_addr <= load_addr + 1'b1;
                    end
                    FINISH: begin
                        prog_mode <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready  = (state_q == RECV);
    assign ram_addr  = prog_mode ? load_addr : cpu_addr;
    assign ram_wdata = prog_mode ? data_q    : cpu_wdata;
    assign ram_we    = prog_mode ? ld_we     : cpu_ri;
    assign ram_oe    = prog_mode ? 1'b0      : cpu_ro;
    assign conflict  = ~prog_mode & cpu_ri & cpu_ro;

endmodule

// File: tb/tb_ram_load_arbiter.sv
// Scoreboard bench for ram_load_arbiter: stimulus queues expected RAM writes and
// checksums, a negedge monitor pops and compares them as the DUT produces them.
module tb_ram_load_arbiter;

    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int LOAD_LEN  = 16;
    localparam int WR_CYCLES = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_ri = 1'b0, cpu_ro = 1'b0;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we, ram_oe, prog_mode, cpu_rst_n, busy, done, err, conflict;
    logic [DATA_W-1:0] checksum;

    ram_load_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_LEN(LOAD_LEN), .WR_CYCLES(WR_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ri(cpu_ri), .cpu_ro(cpu_ro),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_oe(ram_oe),
        .prog_mode(prog_mode), .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done),
        .err(err), .checksum(checksum), .conflict(conflict)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               wr_q[$];
    logic [DATA_W-1:0] sum_q[$];
    int                checks = 0;
    int                errors = 0;
    int                done_cnt = 0;
    int                gaps[3] = '{0, 3, 7};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // monitor: reassembles each loader write burst and checks it against the queue
    initial begin
        logic              prev_we = 1'b0;
        logic              chk_rel = 1'b0;
        int                run = 0;
        logic [ADDR_W-1:0] cur_a = '0;
        logic [DATA_W-1:0] cur_d = '0;
        wr_t               e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_we = 1'b0;
                run     = 0;
                chk_rel = 1'b0;
            end else begin
                if (chk_rel) begin
                    chk("cpu_rst_n release after done", cpu_rst_n, 1);
                    chk_rel = 1'b0;
                end
                if (prog_mode) begin
                    chk("ram_oe in prog_mode", ram_oe, 0);
                    chk("conflict in prog_mode", conflict, 0);
                end
                if (prog_mode && ram_we) begin
                    chk("in_ready during write", in_ready, 0);
                    if (!prev_we) begin
                        cur_a = ram_addr;
                        cur_d = ram_wdata;
                        run   = 1;
                    end else begin
                        run++;
                        chk("write addr stable", ram_addr, cur_a);
                        chk("write data stable", ram_wdata, cur_d);
                    end
                end else if (prev_we) begin
                    if (wr_q.size() == 0) begin
                        fail_now("unexpected ram write");
                    end else begin
                        e = wr_q.pop_front();
                        chk("write addr", cur_a, e.addr);
                        chk("write data", cur_d, e.data);
                        chk("write length", run, WR_CYCLES);
                    end
                end
                prev_we = prog_mode && ram_we;
                if (done) begin
                    done_cnt++;
                    chk("prog_mode at done", prog_mode, 0);
                    chk("cpu_rst_n at done", cpu_rst_n, 0);
                    chk("busy at done", busy, 0);
                    chk("err at done", err, 0);
                    if (sum_q.size() == 0) fail_now("unexpected done pulse");
                    else chk("checksum", checksum, sum_q.pop_front());
                    chk_rel = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic start_load();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("prog_mode unchanged in ARM", prog_mode, 0);
        @(negedge clk);
        chk("prog_mode in RECV", prog_mode, 1);
        chk("busy in RECV", busy, 1);
        chk("cpu_rst_n held in RECV", cpu_rst_n, 0);
        chk("in_ready in RECV", in_ready, 1);
        chk("ram_we idle in RECV", ram_we, 0);
        chk("ram_addr start", ram_addr, 0);
    endtask

    task automatic send(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        wr_q.push_back({a, d});
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("in_ready timeout");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic full_load(input logic [DATA_W-1:0] base, input bit bp, input logic [DATA_W-1:0] exp_sum);
        int d0 = done_cnt;
        int n  = 0;
        sum_q.push_back(exp_sum);
        start_load();
        for (int i = 0; i < LOAD_LEN; i++)
            send(ADDR_W'(i), base + DATA_W'(i), bp ? gaps[i % 3] : 0);
        while (done_cnt == d0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now("done timeout");
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        cpu_addr = 4'h5; cpu_ri = 1'b1; cpu_wdata = 8'h3C;
        #12;
        chk("rst prog_mode", prog_mode, 0);
        chk("rst cpu_rst_n", cpu_rst_n, 0);
        chk("rst in_ready", in_ready, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst checksum", checksum, 0);
        chk("cpu ram_addr", ram_addr, 4'h5);
        chk("cpu ram_we", ram_we, 1);
        chk("cpu ram_wdata", ram_wdata, 8'h3C);
        @(negedge clk);
        rst = 1'b1;
        chk("cpu_rst_n before edge", cpu_rst_n, 0);
        @(negedge clk);
        chk("cpu_rst_n after release", cpu_rst_n, 1);
        chk("prog_mode idle", prog_mode, 0);
        cpu_ri = 1'b0;

        // streamed load 0x10..0x1F
        full_load(8'h10, 1'b0, 8'h78);

        // abort in IDLE has no effect
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort idle err", err, 0);
        chk("abort idle cpu_rst_n", cpu_rst_n, 1);

        // backpressured load with CPU strobes fighting for the port
        cpu_ri = 1'b1; cpu_ro = 1'b1; cpu_addr = 4'hA; cpu_wdata = 8'h55;
        full_load(8'h21, 1'b1, 8'h88);
        chk("conflict out of prog", conflict, 1);
        chk("cpu ram_addr after load", ram_addr, 4'hA);
        chk("cpu ram_oe after load", ram_oe, 1);
        cpu_ri = 1'b0; cpu_ro = 1'b0;

        // abort during the write of address 4
        start_load();
        for (int i = 0; i < 5; i++) send(ADDR_W'(i), 8'hA0 + DATA_W'(i), 0);
        n = 0;
        while (ram_we && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) fail_now("write end timeout");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort err", err, 1);
        chk("abort prog_mode", prog_mode, 0);
        chk("abort busy", busy, 0);
        chk("abort cpu_rst_n", cpu_rst_n, 0);
        repeat (3) @(negedge clk);
        chk("cpu held after abort", cpu_rst_n, 0);
        chk("checksum after abort", checksum, 8'h2A);

        // clean reload clears err and releases the CPU
        full_load(8'hF3, 1'b1, 8'hA8);
        chk("err cleared", err, 0);
        chk("cpu running", cpu_rst_n, 1);

        // async reset while waiting for byte 9
        start_load();
        for (int i = 0; i < 9; i++) send(ADDR_W'(i), DATA_W'(i + 1), 0);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) fail_now("recv timeout");
        chk("checksum before rst", checksum, 8'h2D);
        #2 rst = 1'b0;
        #1;
        chk("async prog_mode", prog_mode, 0);
        chk("async busy", busy, 0);
        chk("async in_ready", in_ready, 0);
        chk("async cpu_rst_n", cpu_rst_n, 0);
        chk("async checksum", checksum, 0);
        chk("async ram_we", ram_we, 0);
        chk("async err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        chk("done count", done_cnt, 3);
        chk("writes drained", wr_q.size(), 0);
        chk("sums drained", sum_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_load_arbiter.md
Name: ram_load_arbiter

Overview:
- Owns the single RAM port of the 8-bit core and arbitrates it between the CPU control lines (mi/ri/ro path via MAR) and an external byte-stream program loader.
- On a load request it:
  - asserts prog_mode, which freezes the microcode sequencer;
  - holds the CPU in reset;
  - accepts LOAD_LEN bytes over a valid/ready handshake and writes them to consecutive RAM addresses;
  - releases the CPU to run from address 0.
- Sits between the control decoder/MAR and the RAM macro.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM/bus data width.
- LOAD_LEN, 16, bytes per load. Legal range 1..2^ADDR_W.
- WR_CYCLES, 2, ram_we pulse width per loaded byte, in clk cycles (≥1).

Ports:
- clk  in  1  system clock; block is posedge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  level-sampled load request; acted on only in IDLE.
- abort  in  1  cancels an in-progress load.
- in_valid  in  1  loader byte valid.
- in_data  in  DATA_W  loader byte.
- in_ready  out  1  byte accepted when in_valid&in_ready at posedge.
- cpu_addr  in  ADDR_W  MAR value.
- cpu_wdata  in  DATA_W  CPU bus value for RAM writes.
- cpu_ri  in  1  CPU RAM-in strobe.
- cpu_ro  in  1  CPU RAM-out strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_oe  out  1  RAM output enable.
- prog_mode  out  1  to decoder; 1 = CPU frozen.
- cpu_rst_n  out  1  CPU reset, active-low.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on successful load completion.
- err  out  1  sticky abort flag.
- checksum  out  DATA_W  mod-2^DATA_W sum of bytes accepted in current/last load.
- conflict  out  1  cpu_ri&cpu_ro both high while prog_mode=0 (combinational).

Behaviour:

Reset (rst low, async):
- state=IDLE, load_addr=0, wr_cnt=0, data_q=0, checksum=0.
- prog_mode=0, cpu_rst_n=0, in_ready=0, busy=0, done=0, err=0.
- First posedge after release, in IDLE: cpu_rst_n←1.

RAM mux (combinational on prog_mode):
- prog_mode=0: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_ri, ram_oe=cpu_ro.
- prog_mode=1: ram_addr=load_addr, ram_wdata=data_q, ram_we=loader strobe (registered), ram_oe=0.
- CPU strobes are ignored while prog_mode=1.

States:
- IDLE: in_ready=0, busy=0, cpu_rst_n=1 unless err=1.
  - start=1 → ARM; clear err, checksum, load_addr.
- ARM (1 cycle): prog_mode←1, cpu_rst_n←0, busy←1 → RECV.
  - prog_mode and cpu_rst_n change no earlier than the first posedge after start is sampled.
- RECV: in_ready=1.
  - On handshake: data_q←in_data, checksum←checksum+in_data, in_ready←0, go WRITE.
  - in_valid held low: stay in RECV indefinitely. There is no timeout.
- WRITE: ram_we=1 for exactly WR_CYCLES cycles; address and data are stable throughout.
  - Then: if load_addr==LOAD_LEN-1 → FINISH; else load_addr←load_addr+1 → RECV.
  - Back-to-back bytes: in_ready is low for WR_CYCLES+1 cycles between handshakes.
- FINISH (1 cycle): prog_mode←0, busy←0, done←1 (single cycle) → IDLE. In IDLE, cpu_rst_n←1 one cycle after prog_mode falls, so the CPU restarts at PC=0 with the decoder unfrozen.
- Abort:
  - abort=1 in ARM/RECV/WRITE: a write in progress completes its current cycle, then ram_we is forced low next cycle. Go IDLE, err←1, busy←0, prog_mode←0.
  - cpu_rst_n stays 0 while err=1, so a partial image never runs; only a successful load or rst clears it.
  - abort in IDLE/FINISH is ignored.
  - Simultaneous abort and handshake in RECV: abort wins, byte not written, checksum unchanged.

Other rules:
- start while busy: ignored, no restart.
- load_addr never wraps within a load. LOAD_LEN=2^ADDR_W ends at all-ones.
- checksum wraps mod 2^DATA_W and holds after FINISH until the next start.
- Async reset mid-WRITE drops ram_we immediately.

Test Plan:
- Reset then idle: rst low→high, cpu_addr=5, cpu_ri=1, cpu_wdata=0x3C → ram_addr=5, ram_we=1, ram_wdata=0x3C; cpu_rst_n=1 after one clk; prog_mode=0.
- Full load, LOAD_LEN=16, bytes 0x10..0x1F streamed with in_valid always high:
  - each byte written at addr 0..15, ram_we high WR_CYCLES=2 cycles each;
  - checksum=0x78; done pulses once;
  - prog_mode falls, then cpu_rst_n rises one cycle later.
- Backpressure: in_valid gaps of 0/3/7 cycles between bytes → the same 16 writes occur, no duplicate or skipped address, in_ready low during WRITE.
- Abort after 5 bytes (during WRITE of addr 4) → addr 4 write completes, err=1, prog_mode=0, cpu_rst_n stays 0, no done pulse. A subsequent start and full load clears err and releases the CPU.
- Arbitration: during a load, drive cpu_ri=1, cpu_addr=0xA → RAM sees only loader address/data, ram_oe=0. With prog_mode=0, cpu_ri=cpu_ro=1 → conflict=1.
- Async rst asserted mid-RECV at byte 9 → all outputs at reset values immediately, in the same cycle, with no clock edge required.
